// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: bus widths and FSM state encoding.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory handshake signals.
// The master modport is the requester/memory side, the slave modport is the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output mem_rdata_i, mem_ready_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  mem_rdata_i, mem_ready_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles in which a fetch request was denied.
module starve_counter #(
  parameter  int LIMIT = 4,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: load/store normally has priority over
// instruction fetch, but a fetch starved for STARVE_LIMIT cycles wins next.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic              if_gnt;
  logic              ls_gnt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_at_limit;

  assign starve_at_limit = (starve_cnt == LIMIT_C);

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clock_i),
    .rst_n (reset_i),
    .inc_i (bus.if_req_i && !if_gnt),
    .clr_i (if_gnt),
    .cnt_o (starve_cnt)
  );

  // Grant arbitration, request latching and completion handling.
  // Grants are gated with reset_i so they stay low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (reset_i) begin
          if (bus.ls_req_i && !(bus.if_req_i && starve_at_limit)) begin
            ls_gnt = 1'b1;
          end else if (bus.if_req_i) begin
            if_gnt = 1'b1;
          end
        end
        if (ls_gnt) begin
          addr_d  = bus.ls_addr_i;
          we_d    = bus.ls_we_i;
          wdata_d = bus.ls_wdata_i;
          state_d = LS_BUSY;
        end else if (if_gnt) begin
          addr_d  = bus.if_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
          state_d = IF_BUSY;
        end
      end

      IF_BUSY: begin
        if (bus.mem_ready_i) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata_i;
          state_d     = IDLE;
        end
      end

      LS_BUSY: begin
        if (bus.mem_ready_i) begin
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = bus.mem_rdata_i;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.ls_rvalid_o = ls_rvalid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.mem_req_o   = (state_q != IDLE);
  assign bus.mem_we_o    = (state_q == LS_BUSY) && we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    bit          is_ls;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   arb_cnt;
  int   if_idx;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr,
                               input logic ls_req, input logic ls_we,
                               input logic [31:0] ls_addr, input logic [31:0] ls_wdata,
                               input logic mem_ready, input logic [31:0] mem_rdata);
    bus.if_req_i    = if_req;
    bus.if_addr_i   = if_addr;
    bus.ls_req_i    = ls_req;
    bus.ls_we_i     = ls_we;
    bus.ls_addr_i   = ls_addr;
    bus.ls_wdata_i  = ls_wdata;
    bus.mem_ready_i = mem_ready;
    bus.mem_rdata_i = mem_rdata;
  endtask

  task automatic expectResp(input bit is_ls, input bit chk_data, input logic [31:0] data);
    exp_t e;
    e.is_ls    = is_ls;
    e.chk_data = chk_data;
    e.data     = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scoreResp(input bit is_ls, input logic [31:0] rdata);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL unexpected_rvalid: got %s pulse, expected none",
               is_ls ? "ls" : "if");
    end else begin
      e = exp_q.pop_front();
      checkOutput("rvalid_owner_is_ls", {31'd0, is_ls}, {31'd0, e.is_ls});
      if (e.chk_data) checkOutput("rdata", rdata, e.data);
    end
  endtask

  // Monitor: every rvalid pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.if_rvalid_o) scoreResp(1'b0, bus.if_rdata_o);
      if (bus.ls_rvalid_o) scoreResp(1'b1, bus.ls_rdata_o);
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_mem_req", {31'd0, bus.mem_req_o}, 0);
    checkOutput("reset_if_gnt", {31'd0, bus.if_gnt_o}, 0);
    checkOutput("reset_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch only, memory ready at once: grant c0, address c1, rvalid c2.
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 1, 32'h1111_2222);
    #1;
    checkOutput("t1_if_gnt", {31'd0, bus.if_gnt_o}, 1);
    checkOutput("t1_mem_req_idle", {31'd0, bus.mem_req_o}, 0);
    expectResp(0, 1, 32'h1111_2222);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
    #1;
    checkOutput("t1_mem_req", {31'd0, bus.mem_req_o}, 1);
    checkOutput("t1_mem_addr", bus.mem_addr_o, 32'h10);
    checkOutput("t1_if_gnt_busy", {31'd0, bus.if_gnt_o}, 0);
    tick();
    checkOutput("t1_if_rvalid", {31'd0, bus.if_rvalid_o}, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Simultaneous fetch and load: load first, fetch after load completes.
    applyStimulus(1, 32'h30, 1, 0, 32'h200, 0, 1, 32'hAAAA_0200);
    #1;
    checkOutput("t2_ls_gnt", {31'd0, bus.ls_gnt_o}, 1);
    checkOutput("t2_if_gnt_denied", {31'd0, bus.if_gnt_o}, 0);
    expectResp(1, 1, 32'hAAAA_0200);
    tick();
    applyStimulus(1, 32'h30, 0, 0, 0, 0, 1, 32'hAAAA_0200);
    #1;
    checkOutput("t2_mem_addr_ls", bus.mem_addr_o, 32'h200);
    checkOutput("t2_mem_we_load", {31'd0, bus.mem_we_o}, 0);
    checkOutput("t2_if_gnt_busy", {31'd0, bus.if_gnt_o}, 0);
    tick();
    applyStimulus(1, 32'h30, 0, 0, 0, 0, 1, 32'h5555_0030);
    #1;
    checkOutput("t2_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 1);
    checkOutput("t2_if_gnt_after", {31'd0, bus.if_gnt_o}, 1);
    expectResp(0, 1, 32'h5555_0030);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5555_0030);
    #1;
    checkOutput("t2_mem_addr_if", bus.mem_addr_o, 32'h30);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Starvation: load held continuously. Denied-fetch count reaches 4 after
    // two load grants plus their busy cycles, so fetch wins the 3rd arbitration.
    applyStimulus(1, 32'h50, 1, 0, 32'h300, 0, 1, 32'hC0DE_0001);
    arb_cnt = 0;
    if_idx  = 0;
    for (int c = 0; c < 16 && if_idx == 0; c++) begin
      #1;
      if (bus.ls_gnt_o) begin
        arb_cnt++;
        expectResp(1, 1, 32'hC0DE_0001);
      end
      if (bus.if_gnt_o) begin
        arb_cnt++;
        if_idx = arb_cnt;
        expectResp(0, 1, 32'hC0DE_0001);
      end
      if (if_idx == 0) tick();
    end
    checkOutput("t3_if_grant_arbitration", 32'(if_idx), 32'd3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hC0DE_0001);
    #1;
    checkOutput("t3_starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
    tick();
    checkOutput("t3_if_rvalid", {31'd0, bus.if_rvalid_o}, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Store with memory ready delayed three cycles.
    applyStimulus(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 0);
    #1;
    checkOutput("t4_ls_gnt", {31'd0, bus.ls_gnt_o}, 1);
    expectResp(1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t4_mem_req", {31'd0, bus.mem_req_o}, 1);
      checkOutput("t4_mem_we", {31'd0, bus.mem_we_o}, 1);
      checkOutput("t4_mem_addr", bus.mem_addr_o, 32'h40);
      checkOutput("t4_mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
      checkOutput("t4_ls_rvalid_early", {31'd0, bus.ls_rvalid_o}, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("t4_mem_addr_ready", bus.mem_addr_o, 32'h40);
    tick();
    checkOutput("t4_ls_rvalid", {31'd0, bus.ls_rvalid_o}, 1);
    checkOutput("t4_mem_we_idle", {31'd0, bus.mem_we_o}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset during LS_BUSY abandons the load; a fetch afterwards works.
    applyStimulus(0, 0, 1, 0, 32'h80, 0, 0, 0);
    #1;
    checkOutput("t5_ls_gnt", {31'd0, bus.ls_gnt_o}, 1);
    tick();
    applyStimulus(1, 32'h90, 0, 0, 0, 0, 1, 32'hBAD0_0080);
    #1;
    checkOutput("t5_mem_req_busy", {31'd0, bus.mem_req_o}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_mem_req", {31'd0, bus.mem_req_o}, 0);
    checkOutput("t5_rst_mem_addr", bus.mem_addr_o, 0);
    checkOutput("t5_rst_if_gnt", {31'd0, bus.if_gnt_o}, 0);
    checkOutput("t5_rst_ls_gnt", {31'd0, bus.ls_gnt_o}, 0);
    checkOutput("t5_rst_if_rdata", bus.if_rdata_o, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("t5_no_ls_rvalid_a", {31'd0, bus.ls_rvalid_o}, 0);
    tick();
    checkOutput("t5_no_ls_rvalid_b", {31'd0, bus.ls_rvalid_o}, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h600D_0100);
    #1;
    checkOutput("t5_if_gnt", {31'd0, bus.if_gnt_o}, 1);
    expectResp(0, 1, 32'h600D_0100);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h600D_0100);
    #1;
    checkOutput("t5_mem_addr_if", bus.mem_addr_o, 32'h100);
    tick();
    checkOutput("t5_if_rvalid", {31'd0, bus.if_rvalid_o}, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
